hilo_acc: RTL and testbench

Parametrised HI/LO special-register unit: the successor to the plain HI/LO pair. It adds independent HI and LO write enables (MTHI/MTLO), a multi-cycle multiply-accumulate engine (MADD/MADDU/MSUB/MSUBU) with a busy/done handshake, an abort input, and optional write-to-read bypass. It sits between EX/MEM writeback and the EX-stage read path. The pipeline stalls on `acc_busy`.

---
 rtl/hilo_acc.sv | 211 +++++++++++++++++++++
 tb/tb_hilo_acc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc.sv
// hilo_acc -- HI/LO special-register unit with multiply-accumulate engine.
//
// Holds the HI and LO halves of a 2*DATA_W accumulator. In IDLE, HI and LO
// can be written directly and independently. A three-state engine
// (IDLE -> MUL -> ACC) multiplies two latched operands and adds the product
// to, or subtracts it from, {HI,LO}. The engine can be aborted with
// acc_cancel.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   we_hi/we_lo  direct write enables for HI / LO (honoured only in IDLE)
//   hi_i/lo_i    direct write data
//   acc_start    start an accumulate (sampled only in IDLE)
//   acc_op       00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU
//   acc_a/acc_b  multiplier operands, latched at start
//   acc_cancel   abort an in-flight accumulate (MUL or ACC)
//   acc_busy     high while in MUL or ACC
//   acc_done     one-cycle pulse after {HI,LO} has been updated
//   wr_conflict  one-cycle pulse when a direct write was dropped (busy)
//   hi_o/lo_o    HI/LO read data (optionally bypassing direct-write data)
module hilo_acc #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              acc_start,
  input  logic [1:0]        acc_op,
  input  logic [DATA_W-1:0] acc_a,
  input  logic [DATA_W-1:0] acc_b,
  input  logic              acc_cancel,
  output logic              acc_busy,
  output logic              acc_done,
  output logic              wr_conflict,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic BYP_EN = (BYPASS != 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_ACC  = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              done_q, done_d;
  logic              conflict_q, conflict_d;

  logic              busy_s;
  logic [PW-1:0]     ext_a_s, ext_b_s, mul_s, hilo_s, sum_s;

  // Widen an operand to the product width: op bit 0 selects zero-extension
  // (unsigned ops) versus sign-extension (signed ops).
  function automatic logic [PW-1:0] extend_op(input logic [DATA_W-1:0] v,
                                              input logic is_unsigned);
    if (is_unsigned) begin
      extend_op = {{DATA_W{1'b0}}, v};
    end else begin
      extend_op = {{DATA_W{v[DATA_W-1]}}, v};
    end
  endfunction

  // Multiplier and accumulator arithmetic. Multiplying the two PW-bit
  // extended operands and keeping the low PW bits yields the exact signed
  // or unsigned product, so one multiplier serves all four ops.
  always_comb begin
    ext_a_s = extend_op(a_q, op_q[0]);
    ext_b_s = extend_op(b_q, op_q[0]);
    mul_s   = ext_a_s * ext_b_s;
    hilo_s  = {hi_q, lo_q};
    if (op_q[1]) begin
      sum_s = hilo_s - prod_q;
    end else begin
      sum_s = hilo_s + prod_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel returns to IDLE from either busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_start) state_d = ST_MUL;
        else           state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (acc_cancel) state_d = ST_IDLE;
        else            state_d = ST_ACC;
      end
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      ST_IDLE: busy_s = 1'b0;
      ST_MUL:  busy_s = 1'b1;
      ST_ACC:  busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Datapath next values. A direct write and a start in the same IDLE
  // cycle both land; the accumulate then sees the freshly written value.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    prod_d     = prod_q;
    done_d     = 1'b0;
    conflict_d = busy_s & (we_hi | we_lo);
    case (state_q)
      ST_IDLE: begin
        if (we_hi) hi_d = hi_i;
        else       hi_d = hi_q;
        if (we_lo) lo_d = lo_i;
        else       lo_d = lo_q;
        if (acc_start) begin
          a_d  = acc_a;
          b_d  = acc_b;
          op_d = acc_op;
        end else begin
          a_d  = a_q;
          b_d  = b_q;
          op_d = op_q;
        end
      end
      ST_MUL: begin
        if (!acc_cancel) prod_d = mul_s;
        else             prod_d = prod_q;
      end
      ST_ACC: begin
        // Cancel wins over the accumulator write on the same edge.
        if (!acc_cancel) begin
          {hi_d, lo_d} = sum_s;
          done_d       = 1'b1;
        end else begin
          done_d       = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q       <= {DATA_W{1'b0}};
      lo_q       <= {DATA_W{1'b0}};
      a_q        <= {DATA_W{1'b0}};
      b_q        <= {DATA_W{1'b0}};
      op_q       <= 2'b00;
      prod_q     <= {PW{1'b0}};
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      prod_q     <= prod_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  // Read ports: optional same-cycle forwarding of direct-write data, only
  // when the write will actually land (IDLE).
  always_comb begin
    if (BYP_EN && !busy_s && we_hi) hi_o = hi_i;
    else                            hi_o = hi_q;
    if (BYP_EN && !busy_s && we_lo) lo_o = lo_i;
    else                            lo_o = lo_q;
  end

  assign acc_busy    = busy_s;
  assign acc_done    = done_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_hilo_acc.sv
// Self-checking bench for hilo_acc: directed scenarios plus randomized
// accumulates, with a scoreboard queue of expected {HI,LO} values checked by
// a monitor on every acc_done pulse.
module tb_hilo_acc;

  logic        clk;
  logic        rst;
  logic        we_hi, we_lo, acc_start, acc_cancel;
  logic [31:0] hi_i, lo_i, acc_a, acc_b;
  logic [1:0]  acc_op;

  logic        acc_busy, acc_done, wr_conflict;
  logic [31:0] hi_o, lo_o;
  logic        b_busy, b_done, b_conf;
  logic [31:0] b_hi, b_lo;

  hilo_acc #(.DATA_W(32), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
    .acc_start(acc_start), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .acc_cancel(acc_cancel), .acc_busy(acc_busy), .acc_done(acc_done),
    .wr_conflict(wr_conflict), .hi_o(hi_o), .lo_o(lo_o)
  );

  hilo_acc #(.DATA_W(32), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
    .acc_start(acc_start), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .acc_cancel(acc_cancel), .acc_busy(b_busy), .acc_done(b_done),
    .wr_conflict(b_conf), .hi_o(b_hi), .lo_o(b_lo)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int conflict_seen = 0;
  int conflict_exp = 0;
  logic [63:0] model_acc;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed/unsigned product, then add/subtract mod 2^64.
  function automatic logic [63:0] acc_ref(input logic [63:0] cur, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    if (op[0]) begin
      p = {32'h0, a} * {32'h0, b};
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = 64'(sa * sb);
    end
    return op[1] ? cur - p : cur + p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare result on each acc_done against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (acc_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending accumulate");
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_result", {hi_o, lo_o}, mon_e);
          chk("busy_low_with_done", {63'h0, acc_busy}, 64'h0);
        end
      end
      if (wr_conflict) conflict_seen++;
    end
  end

  task automatic write_direct(input logic wh, input logic wl,
                              input logic [31:0] h, input logic [31:0] l);
    we_hi = wh; we_lo = wl; hi_i = h; lo_i = l;
    tick();
    if (wh) model_acc[63:32] = h;
    if (wl) model_acc[31:0] = l;
    we_hi = 1'b0; we_lo = 1'b0;
    chk("direct_write", {hi_o, lo_o}, model_acc);
  endtask

  task automatic do_acc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wl, input logic [31:0] lv, input logic cn);
    int d0, n;
    acc_start = 1'b1; acc_op = op; acc_a = a; acc_b = b;
    we_lo = wl; lo_i = lv; acc_cancel = cn;
    tick();
    acc_start = 1'b0; we_lo = 1'b0; acc_cancel = 1'b0;
    if (wl) model_acc[31:0] = lv;
    model_acc = acc_ref(model_acc, op, a, b);
    exp_q.push_back(model_acc);
    chk("busy_after_start", {63'h0, acc_busy}, 64'h1);
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_latency", 64'(n), 64'd3);
    tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {29'h0, acc_busy, acc_done, wr_conflict, hi_o, lo_o}, 64'h0);
    chk(name, {29'h0, b_busy, b_done, b_conf, b_hi, b_lo}, 64'h0);
  endtask

  initial begin
    int d0;
    rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; acc_start = 1'b0; acc_cancel = 1'b0;
    hi_i = 32'h0; lo_i = 32'h0; acc_a = 32'h0; acc_b = 32'h0; acc_op = 2'b00;
    model_acc = 64'h0;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Direct writes: HI only, then both halves.
    write_direct(1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
    chk("hi_only_write", {hi_o, lo_o}, 64'h1234_5678_0000_0000);
    write_direct(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);

    // Signed MADD cases.
    write_direct(1'b1, 1'b1, 32'h0, 32'h5);
    do_acc(2'b00, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0);
    chk("madd_3x4", {hi_o, lo_o}, 64'h0000_0000_0000_0011);
    write_direct(1'b1, 1'b1, 32'h0, 32'h0);
    do_acc(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'h0, 1'b0);
    chk("madd_neg2x3", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);

    // MADDU and MSUBU.
    write_direct(1'b1, 1'b1, 32'h0, 32'h0);
    do_acc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    chk("maddu_max", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    write_direct(1'b1, 1'b1, 32'h0, 32'h0);
    do_acc(2'b11, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0);
    chk("msubu_wrap", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Direct write of LO while in MUL: dropped, one conflict pulse.
    write_direct(1'b1, 1'b1, 32'h0, 32'h10);
    acc_start = 1'b1; acc_op = 2'b00; acc_a = 32'd2; acc_b = 32'd2;
    tick();
    acc_start = 1'b0;
    model_acc = acc_ref(model_acc, 2'b00, 32'd2, 32'd2);
    exp_q.push_back(model_acc);
    we_lo = 1'b1; lo_i = 32'hAAAA_5555;
    tick();
    we_lo = 1'b0;
    conflict_exp++;
    chk("conflict_pulse", {63'h0, wr_conflict}, 64'h1);
    tick();
    chk("conflict_one_cycle", {63'h0, wr_conflict}, 64'h0);
    repeat (2) tick();
    chk("lo_not_overwritten", {hi_o, lo_o}, 64'h0000_0000_0000_0014);

    // Start while in ACC is ignored: exactly one done.
    d0 = done_cnt;
    acc_start = 1'b1; acc_op = 2'b01; acc_a = 32'd6; acc_b = 32'd7;
    tick();
    model_acc = acc_ref(model_acc, 2'b01, 32'd6, 32'd7);
    exp_q.push_back(model_acc);
    acc_start = 1'b0;
    tick();
    acc_start = 1'b1; acc_a = 32'd100; acc_b = 32'd100;
    tick();
    acc_start = 1'b0;
    repeat (4) tick();
    chk("start_in_acc_single_done", 64'(done_cnt - d0), 64'd1);
    chk("start_in_acc_idle", {63'h0, acc_busy}, 64'h0);

    // Start together with a LO write: accumulate uses the new LO.
    write_direct(1'b1, 1'b0, 32'h0, 32'h0);
    do_acc(2'b00, 32'd1, 32'd1, 1'b1, 32'd7, 1'b0);
    chk("start_with_we_lo", {hi_o, lo_o}, 64'h0000_0000_0000_0008);

    // Cancel with start in IDLE: start still accepted.
    do_acc(2'b10, 32'd3, 32'd3, 1'b0, 32'h0, 1'b1);

    // Cancel in ACC: no change, no done, idle on the next cycle.
    write_direct(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);
    acc_start = 1'b1; acc_op = 2'b00; acc_a = 32'd9; acc_b = 32'd9;
    tick();
    acc_start = 1'b0;
    tick();
    acc_cancel = 1'b1;
    tick();
    acc_cancel = 1'b0;
    chk("cancel_acc_busy_low", {63'h0, acc_busy}, 64'h0);
    repeat (3) tick();
    chk("cancel_acc_unchanged", {hi_o, lo_o}, 64'h1111_2222_3333_4444);

    // Cancel in MUL.
    acc_start = 1'b1; acc_op = 2'b01; acc_a = 32'd5; acc_b = 32'd5;
    tick();
    acc_start = 1'b0; acc_cancel = 1'b1;
    tick();
    acc_cancel = 1'b0;
    chk("cancel_mul_busy_low", {63'h0, acc_busy}, 64'h0);
    repeat (3) tick();
    chk("cancel_mul_unchanged", {hi_o, lo_o}, model_acc);

    // Bypass: same-cycle visibility only on the BYPASS=1 instance.
    we_hi = 1'b1; hi_i = 32'hDEAD_BEEF;
    #1;
    chk("bypass_same_cycle", {32'h0, b_hi}, 64'h0000_0000_DEAD_BEEF);
    chk("bypass_lo_register", {32'h0, b_lo}, {32'h0, model_acc[31:0]});
    chk("no_bypass_old_value", {32'h0, hi_o}, {32'h0, model_acc[63:32]});
    tick();
    we_hi = 1'b0;
    model_acc[63:32] = 32'hDEAD_BEEF;
    chk("no_bypass_next_cycle", {32'h0, hi_o}, 64'h0000_0000_DEAD_BEEF);

    // Randomized accumulates and direct writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_direct(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
      do_acc(2'($urandom_range(0, 3)), pick(), pick(),
             1'($urandom_range(0, 3) == 0), $urandom(), 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in MUL.
    write_direct(1'b1, 1'b1, 32'h5555_AAAA, 32'h1234_4321);
    acc_start = 1'b1; acc_op = 2'b00; acc_a = 32'd5; acc_b = 32'd5;
    tick();
    acc_start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset_in_mul");
    model_acc = 64'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    chk("after_reset_regs", {hi_o, lo_o}, 64'h0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("conflict_count", 64'(conflict_seen), 64'(conflict_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
